// File: rtl/tube_scroller_if.sv
// tube_scroller_if
//   Bundles the control inputs and the obstacle-field outputs of tube_scroller.
//
//   Handshake: there is no valid/ready pair on this bus. `start` is a
//   single-cycle request sampled on the rising clock edge. `over` is a level
//   input. Every output is a registered level (or a decode of registered state)
//   and may be sampled on any cycle.
//
//   Signals
//     start      : one-cycle request to begin scrolling
//     over       : collision flag from the collision checker (level)
//     tubeN_x    : tube left-edge x, N = 1..3
//     tubeN_y    : tube gap-centre y, N = 1..3
//     pass       : one-cycle pulse when a tube reaches the pass column
//     running    : high while the scroller is in RUNNING
//     state_dbg  : raw FSM state, for debug and checkers
//
//   Modports: master drives start/over (game control / bench).
//             slave is the scroller itself.
interface tube_scroller_if;
  logic       start;
  logic       over;
  logic [9:0] tube1_x;
  logic [9:0] tube2_x;
  logic [9:0] tube3_x;
  logic [9:0] tube1_y;
  logic [9:0] tube2_y;
  logic [9:0] tube3_y;
  logic       pass;
  logic       running;
  logic [1:0] state_dbg;

  modport master (
    output start, over,
    input  tube1_x, tube2_x, tube3_x, tube1_y, tube2_y, tube3_y,
    input  pass, running, state_dbg
  );

  modport slave (
    input  start, over,
    output tube1_x, tube2_x, tube3_x, tube1_y, tube2_y, tube3_y,
    output pass, running, state_dbg
  );
endinterface

// File: rtl/tube_scroller.sv
// tube_scroller
//   Keeps three tube records (left-edge x, gap-centre y) and scrolls them one
//   pixel left per movement tick while the game is running. A tube leaving the
//   screen at x==0 is recycled to x = 3*SPACING-1 with a pseudo-random gap
//   centre taken from a free-running 10-bit LFSR. `pass` pulses for one cycle
//   after a tick that puts any tube exactly on PASS_X. Positions freeze as
//   soon as `over` is raised while running; only `clr` leaves that state.
//
//   Ports
//     clk  : system clock
//     clr  : synchronous active-high reset
//     bus  : tube_scroller_if.slave (start, over in; tubes, pass, running,
//            state_dbg out)
//
//   Optional feature macro: TUBE_SPEEDUP_EN
//     Defined   : a 2-bit speed level rises every 8th pass (saturating at 3)
//                 and the movement divisor becomes STEP_DIV >> level, applied
//                 at the next prescaler wrap.
//     Undefined : the divisor is fixed at STEP_DIV.
module tube_scroller #(
  parameter int SPACING  = 240,
  parameter int STEP_DIV = 200000,
  parameter int GAP_MIN  = 120,
  parameter int GAP_MAX  = 360,
  parameter int PASS_X   = 100
) (
  input  logic            clk,
  input  logic            clr,
  tube_scroller_if.slave  bus
);

  localparam int         CW       = $clog2(STEP_DIV);
  localparam int         RANGE    = GAP_MAX - GAP_MIN + 1;
  localparam logic [9:0] WRAP_X   = 10'(3 * SPACING - 1);
  localparam logic [9:0] RANGE10  = 10'(RANGE);
  localparam logic [9:0] GMIN10   = 10'(GAP_MIN);
  localparam logic [9:0] PASSX10  = 10'(PASS_X);
  localparam logic [9:0] LFSR_INI = 10'h1A5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    FROZEN  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic            running_c;
  logic            tick;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   lim;
  logic [9:0]      lfsr;
  logic [9:0]      r10;
  logic [9:0]      gap_off;
  logic [9:0]      gap_y;
  logic [9:0]      x_q   [3];
  logic [9:0]      y_q   [3];
  logic [9:0]      x_nxt [3];
  logic            pass_hit;
  logic            pass_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUNNING;
      RUNNING: if (bus.over)  state_nxt = FROZEN;
      FROZEN:  state_nxt = FROZEN;
      default: state_nxt = IDLE;
    endcase
  end

  // `over` qualifies the tick directly so a collision on a tick cycle
  // suppresses that move.
  always_comb begin
    running_c = (state == RUNNING);
    tick      = running_c && (cnt == lim) && !bus.over;
  end

  // ---------------------------------------------------------- prescaler
  // Advances only while running without a collision; otherwise it holds.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (running_c && !bus.over) begin
      cnt <= (cnt == lim) ? '0 : cnt + CW'(1);
    end
  end

`ifdef TUBE_SPEEDUP_EN
  logic [2:0] pass_cnt;
  logic [1:0] level;
  logic [1:0] div_level;

  // div_level is the level actually used by the comparator; it only picks
  // up a new level on a wrap so an interval in progress is never cut short.
  always_ff @(posedge clk) begin
    if (clr) begin
      pass_cnt  <= '0;
      level     <= '0;
      div_level <= '0;
    end else begin
      if (pass_q) begin
        pass_cnt <= pass_cnt + 3'd1;
        if (pass_cnt == 3'd7 && level != 2'd3) level <= level + 2'd1;
      end
      if (tick) div_level <= level;
    end
  end

  assign lim = CW'((STEP_DIV >> div_level) - 1);
`else
  assign lim = CW'(STEP_DIV - 1);
`endif

  // --------------------------------------------------------------- LFSR
  // x^10 + x^7 + 1, shifting left; runs in every state so gap heights depend
  // on how long the player waited before starting.
  always_ff @(posedge clk) begin
    if (clr) lfsr <= LFSR_INI;
    else     lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
  end

  // Fold the 8-bit sample into 0..RANGE-1; a single subtraction suffices
  // because RANGE is at least 128.
  always_comb begin
    r10     = {2'b00, lfsr[7:0]};
    gap_off = (r10 >= RANGE10) ? (r10 - RANGE10) : r10;
    gap_y   = GMIN10 + gap_off;
  end

  // -------------------------------------------------------------- tubes
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      x_nxt[i] = (x_q[i] == 10'd0) ? WRAP_X : (x_q[i] - 10'd1);
    end
    pass_hit = tick && ((x_nxt[0] == PASSX10) ||
                        (x_nxt[1] == PASSX10) ||
                        (x_nxt[2] == PASSX10));
  end

  // Recycled tubes that wrap on the same tick share one gap value.
  always_ff @(posedge clk) begin
    if (clr) begin
      x_q[0] <= 10'd320;
      x_q[1] <= 10'd560;
      x_q[2] <= 10'd800;
      y_q[0] <= 10'd240;
      y_q[1] <= 10'd240;
      y_q[2] <= 10'd150;
      pass_q <= 1'b0;
    end else begin
      pass_q <= pass_hit;
      if (tick) begin
        for (int i = 0; i < 3; i++) begin
          x_q[i] <= x_nxt[i];
          if (x_q[i] == 10'd0) y_q[i] <= gap_y;
        end
      end
    end
  end

  // ------------------------------------------------------------ outputs
  assign bus.tube1_x   = x_q[0];
  assign bus.tube2_x   = x_q[1];
  assign bus.tube3_x   = x_q[2];
  assign bus.tube1_y   = y_q[0];
  assign bus.tube2_y   = y_q[1];
  assign bus.tube3_y   = y_q[2];
  assign bus.pass      = pass_q;
  assign bus.running   = running_c;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_tube_scroller.sv
module tb_tube_scroller;
  localparam int DIV     = 8;
  localparam int SPACE   = 240;
  localparam int PERIOD  = 3 * SPACE;
  localparam int G_MIN   = 120;
  localparam int G_MAX   = 360;
  localparam int PASS_X  = 100;

  // ------------------------------------------------ clock / reset block
  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  tube_scroller_if bus();

  tube_scroller #(
    .SPACING (SPACE),
    .STEP_DIV(DIV),
    .GAP_MIN (G_MIN),
    .GAP_MAX (G_MAX),
    .PASS_X  (PASS_X)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  // ----------------------------------------------------- reference model
  // Positions are computed from the number of ticks since reset with plain
  // modular arithmetic; ticks are scheduled by absolute edge number.
  typedef enum {M_IDLE, M_RUN, M_FROZEN} mstate_t;
  mstate_t    m_state;
  int         m_x [3];
  int         m_y [3];
  bit         m_pass;
  logic [9:0] m_lfsr;
  int         tick_no;
  int         edge_no   = 0;
  int         next_tick = -1;
  bit         model_on  = 1'b1;
  int         x_init [3] = '{320, 560, 800};

  // scoreboard of recycled gap heights
  logic [9:0] exp_q[$];

  function automatic int x_of(int i, int k);
    int v;
    if (k <= x_init[i]) return x_init[i] - k;
    v = (x_init[i] - k) % PERIOD;
    if (v < 0) v += PERIOD;
    return v;
  endfunction

  function automatic int gap_of(logic [9:0] s);
    int r;
    r = int'(s[7:0]);
    return G_MIN + (r % (G_MAX - G_MIN + 1));
  endfunction

  // polynomial x^10 + x^7 + 1: new bit = s9 xor s6, shifted in at the bottom
  function automatic logic [9:0] lfsr_adv(logic [9:0] s);
    return {s[8:0], s[9] ^ s[6]};
  endfunction

  task automatic m_reset();
    m_state   = M_IDLE;
    tick_no   = 0;
    next_tick = -1;
    m_lfsr    = 10'h1A5;
    m_pass    = 1'b0;
    m_y       = '{240, 240, 150};
    for (int i = 0; i < 3; i++) m_x[i] = x_of(i, 0);
    exp_q.delete();
  endtask

  task automatic model_edge(input bit c, input bit s, input bit o, output bit [2:0] wrapped);
    bit tick;
    wrapped = '0;
    if (c) begin
      m_reset();
      return;
    end
    tick   = (m_state == M_RUN) && (edge_no == next_tick) && !o;
    m_pass = 1'b0;
    if (tick) begin
      tick_no++;
      next_tick += DIV;
      for (int i = 0; i < 3; i++) begin
        if (x_of(i, tick_no - 1) == 0) begin
          wrapped[i] = 1'b1;
          m_y[i] = gap_of(m_lfsr);
          exp_q.push_back(10'(m_y[i]));
        end
        m_x[i] = x_of(i, tick_no);
        if (m_x[i] == PASS_X) m_pass = 1'b1;
      end
    end
    case (m_state)
      M_IDLE: if (s) begin
        m_state   = M_RUN;
        next_tick = edge_no + DIV;
      end
      M_RUN:  if (o) m_state = M_FROZEN;
      default: ;
    endcase
    m_lfsr = lfsr_adv(m_lfsr);
  endtask

  function automatic logic [9:0] dut_x(int i);
    case (i)
      0: return bus.tube1_x;
      1: return bus.tube2_x;
      default: return bus.tube3_x;
    endcase
  endfunction

  function automatic logic [9:0] dut_y(int i);
    case (i)
      0: return bus.tube1_y;
      1: return bus.tube2_y;
      default: return bus.tube3_y;
    endcase
  endfunction

  task automatic check_model(input bit [2:0] wrapped);
    bit         ok;
    logic [9:0] e;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (dut_x(i) !== 10'(m_x[i]) || dut_y(i) !== 10'(m_y[i])) ok = 1'b0;
    end
    if (bus.pass !== m_pass || bus.running !== (m_state == M_RUN)) ok = 1'b0;
    vec_cnt++;
    if (!ok) begin
      err_cnt++;
      $display("FAIL model edge %0d: got x=%0d/%0d/%0d y=%0d/%0d/%0d pass=%b run=%b, required x=%0d/%0d/%0d y=%0d/%0d/%0d pass=%b run=%b",
               edge_no, bus.tube1_x, bus.tube2_x, bus.tube3_x, bus.tube1_y, bus.tube2_y, bus.tube3_y,
               bus.pass, bus.running, m_x[0], m_x[1], m_x[2], m_y[0], m_y[1], m_y[2],
               m_pass, (m_state == M_RUN));
    end
    for (int i = 0; i < 3; i++) begin
      if (wrapped[i]) begin
        e = exp_q.pop_front();
        vec_cnt++;
        if (dut_y(i) !== e || dut_y(i) < 10'(G_MIN) || dut_y(i) > 10'(G_MAX)) begin
          err_cnt++;
          $display("FAIL gap tube%0d edge %0d: got y=%0d, required %0d (range %0d..%0d)",
                   i + 1, edge_no, dut_y(i), e, G_MIN, G_MAX);
        end
      end
      if (dut_x(i) == 10'(PERIOD - 1)) begin
        vec_cnt++;
        if (dut_x((i + 1) % 3) !== 10'(PERIOD - 1 - SPACE * 2) ||
            dut_x((i + 2) % 3) !== 10'(PERIOD - 1 - SPACE)) begin
          err_cnt++;
          $display("FAIL spacing edge %0d: got x=%0d/%0d/%0d, required others at %0d and %0d",
                   edge_no, bus.tube1_x, bus.tube2_x, bus.tube3_x,
                   PERIOD - 1 - 2 * SPACE, PERIOD - 1 - SPACE);
        end
      end
    end
  endtask

  // -------------------------------------------------------- driver tasks
  task automatic step(input bit c, input bit s, input bit o);
    bit [2:0] wr;
    clr       = c;
    bus.start = s;
    bus.over  = o;
    @(posedge clk);
    edge_no++;
    model_edge(c, s, o, wr);
    #1;
    if (model_on) check_model(wr);
  endtask

  task automatic expect_x(input string name, input int a, input int b, input int c3);
    vec_cnt++;
    if (bus.tube1_x !== 10'(a) || bus.tube2_x !== 10'(b) || bus.tube3_x !== 10'(c3)) begin
      err_cnt++;
      $display("FAIL %s: got x=%0d/%0d/%0d, required %0d/%0d/%0d",
               name, bus.tube1_x, bus.tube2_x, bus.tube3_x, a, b, c3);
    end
  endtask

  // ------------------------------------------------------- vector table
  typedef struct {
    bit c;
    bit s;
    bit o;
    int x1;
    int x2;
    int x3;
    bit run;
    bit pas;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int first_pass;
    int pass_win;
    int start_edge;
    int sx [3];

    bus.start = 1'b0;
    bus.over  = 1'b0;
    m_reset();

    // reset, idle (over ignored), start, first-move latency, ignored start,
    // clr beating start
    tbl[0]  = '{1, 0, 0, 320, 560, 800, 0, 0};
    tbl[1]  = '{0, 0, 0, 320, 560, 800, 0, 0};
    tbl[2]  = '{0, 0, 1, 320, 560, 800, 0, 0};
    tbl[3]  = '{0, 0, 0, 320, 560, 800, 0, 0};
    tbl[4]  = '{0, 1, 0, 320, 560, 800, 1, 0};
    for (int i = 5; i < 12; i++) tbl[i] = '{0, 0, 0, 320, 560, 800, 1, 0};
    tbl[12] = '{0, 0, 0, 319, 559, 799, 1, 0};
    tbl[13] = '{0, 1, 0, 319, 559, 799, 1, 0};
    tbl[14] = '{1, 1, 0, 320, 560, 800, 0, 0};

    repeat (2) @(posedge clk);
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].c, tbl[i].s, tbl[i].o);
      vec_cnt++;
      if (bus.tube1_x !== 10'(tbl[i].x1) || bus.tube2_x !== 10'(tbl[i].x2) ||
          bus.tube3_x !== 10'(tbl[i].x3) || bus.running !== tbl[i].run ||
          bus.pass !== tbl[i].pas) begin
        err_cnt++;
        $display("FAIL table[%0d]: got x=%0d/%0d/%0d run=%b pass=%b, required %0d/%0d/%0d run=%b pass=%b",
                 i, bus.tube1_x, bus.tube2_x, bus.tube3_x, bus.running, bus.pass,
                 tbl[i].x1, tbl[i].x2, tbl[i].x3, tbl[i].run, tbl[i].pas);
      end
    end

    // idle hold with random over and random wait before start
    repeat (50) step(0, 0, 1'($urandom_range(0, 1)));
    expect_x("idle_hold", 320, 560, 800);
    repeat ($urandom_range(0, 40)) step(0, 0, 0);

    // 1000 ticks with stray start pulses
    step(0, 1, 0);
    start_edge = edge_no;
    first_pass = -1;
    pass_win   = 0;
    for (int c = 0; c < 1000 * DIV + DIV && tick_no < 1000; c++) begin
      step(0, 1'($urandom_range(0, 15) == 0), 0);
      if (bus.pass === 1'b1) begin
        if (first_pass < 0) first_pass = edge_no - start_edge;
        if (edge_no - start_edge <= 221 * DIV) pass_win++;
      end
    end
    vec_cnt++;
    if (tick_no < 1000) begin
      err_cnt++;
      $display("FAIL run_budget: got %0d ticks, required 1000", tick_no);
    end
    vec_cnt++;
    if (first_pass != 220 * DIV || pass_win != 1) begin
      err_cnt++;
      $display("FAIL pass_timing: got first pass %0d cycles after start, %0d pulses, required %0d and 1",
               first_pass, pass_win, 220 * DIV);
    end

    // collision on a tick cycle
    for (int g = 0; g < 2 * DIV && edge_no + 1 != next_tick; g++) step(0, 0, 0);
    for (int i = 0; i < 3; i++) sx[i] = m_x[i];
    step(0, 0, 1);
    expect_x("freeze_on_tick", sx[0], sx[1], sx[2]);
    repeat (100) step(0, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    expect_x("frozen_hold", sx[0], sx[1], sx[2]);
    vec_cnt++;
    if (bus.running !== 1'b0) begin
      err_cnt++;
      $display("FAIL frozen_running: got %b, required 0", bus.running);
    end
    step(1, 1, 1);
    expect_x("clr_from_frozen", 320, 560, 800);

    // clr on the very edge that would raise pass
    step(0, 1, 0);
    for (int g = 0; g < 221 * DIV && !(tick_no == 219 && edge_no + 1 == next_tick); g++)
      step(0, 0, 0);
    step(1, 0, 0);
    vec_cnt++;
    if (bus.pass !== 1'b0 || bus.tube1_x !== 10'd320) begin
      err_cnt++;
      $display("FAIL pass_dropped: got pass=%b x1=%0d, required pass=0 x1=320", bus.pass, bus.tube1_x);
    end
    repeat (5) step(0, 0, 0);

`ifdef TUBE_SPEEDUP_EN
    begin
      int         passes;
      int         last_edge;
      int         iv;
      int         last_iv;
      logic [9:0] prev;
      int         seen [$];
      model_on = 1'b0;
      step(1, 0, 0);
      step(0, 1, 0);
      last_edge = edge_no;
      prev      = bus.tube1_x;
      passes    = 0;
      last_iv   = 0;
      for (int c = 0; c < 40000 && passes < 28; c++) begin
        step(0, 0, 0);
        if (bus.pass === 1'b1) passes++;
        if (bus.tube1_x !== prev) begin
          iv = edge_no - last_edge;
          if (seen.size() == 0 || seen[$] != iv) seen.push_back(iv);
          last_iv   = iv;
          last_edge = edge_no;
          prev      = bus.tube1_x;
        end
      end
      vec_cnt++;
      if (passes < 28 || seen.size() != 4 || last_iv != 1) begin
        err_cnt++;
        $display("FAIL speedup: got %0d passes, %0d interval levels, last interval %0d, required 28, 4, 1",
                 passes, seen.size(), last_iv);
      end else begin
        vec_cnt++;
        if (seen[0] != 8 || seen[1] != 4 || seen[2] != 2 || seen[3] != 1) begin
          err_cnt++;
          $display("FAIL speedup_seq: got %0d/%0d/%0d/%0d, required 8/4/2/1",
                   seen[0], seen[1], seen[2], seen[3]);
        end
      end
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/tube_scroller.md
# tube_scroller

Upstream producer of the obstacle field for the collision checker. Holds three tube records (left-edge x, gap-centre y) and scrolls them left one pixel per movement tick while the game runs. Recycles a tube to the right end with a new pseudo-random gap height when it leaves the screen, and pulses `pass` when a tube clears the bird column. Freezes all positions as soon as the collision checker raises `over`.

## Interface
- `SPACING`, 240: horizontal distance between consecutive tubes, pixels.
- `STEP_DIV`, 200000: clock cycles per one-pixel move (must be ≥ 2).
- `GAP_MIN`, 120: smallest gap-centre y for a recycled tube.
- `GAP_MAX`, 360: largest gap-centre y; `RANGE = GAP_MAX-GAP_MIN+1` must be in 128..256.
- `PASS_X`, 100: x value at which a tube counts as passed.
- `clk` in 1: system clock.
- `clr` in 1: reset, synchronous, active-high.
- `start` in 1: one-cycle request to begin scrolling.
- `over` in 1: collision flag from the collision checker; level.
- `tube1_x`, `tube2_x`, `tube3_x` out 10 each: tube left-edge x, registered.
- `tube1_y`, `tube2_y`, `tube3_y` out 10 each: gap-centre y, registered.
- `pass` out 1: one-cycle pulse per tube passing `PASS_X`.
- `running` out 1: high in RUNNING state.

## Operation
- **Reset values** (`clr` high at a clock edge):
  - x1=320, x2=560, x3=800.
  - y1=240, y2=240, y3=150.
  - `pass`=0, `running`=0, state IDLE, prescaler 0, LFSR 10'h1A5.
- **States:**
  - IDLE → RUNNING on `start`.
  - RUNNING → FROZEN when `over`=1.
  - FROZEN is left only by `clr`.
  - `start` is ignored in RUNNING and FROZEN. `over` is ignored in IDLE.
- **Prescaler:**
  - Counts 0..STEP_DIV-1 only in RUNNING. It holds its value in IDLE and FROZEN.
  - `tick` = RUNNING and count==STEP_DIV-1 and `over`=0. The count wraps to 0 on that edge.
- **On tick, each tube independently:**
  - If x≠0: x ← x-1.
  - If x==0: x ← 3·SPACING-1 (719), and y ← new gap.
  - This keeps spacing exact: the other two tubes are at 239 and 479 after the same tick.
- **New gap:**
  - r = LFSR[7:0].
  - y = GAP_MIN + (r ≥ RANGE ? r-RANGE : r). With the defaults y is in 120..360.
- **Simultaneous wraps:** if two tubes wrap on the same tick, both take the same LFSR value.
- **LFSR:**
  - 10-bit Fibonacci, polynomial x^10+x^7+1.
  - Shifts every clock in every state except during `clr`, so gap heights depend on start timing.
  - Never reaches zero.
- **`pass`:** registered; high for the one cycle after a tick whose update sets any x to exactly PASS_X. Two tubes cannot both hit PASS_X, so this is at most one pulse per tick.
- **Width rules:**
  - All x/y arithmetic is 10-bit unsigned.
  - 3·SPACING-1 must be ≤ 1023.
  - No subtraction below 0 occurs because the x==0 case is handled by the wrap.

## Timing
- `start` sampled at edge E0 → `running`=1 after E0. The first move is visible after edge E0+STEP_DIV.
- Positions change only on tick edges. They are stable for STEP_DIV-1 cycles between changes.
- `over` and tick in the same cycle: `over` wins, no move, FROZEN next cycle.
- `over` is sampled combinationally into the tick qualifier. It does not depend on any output of this block in the same cycle.
- `clr` mid-RUNNING: all reset values restored at that edge, and any `pass` in flight is dropped.
- `clr` has priority over `start` and `over` in the same cycle.

## Configuration
- `TUBE_SPEEDUP_EN` defined:
  - A 2-bit speed level (reset 0) increments every 8th `pass` and saturates at 3.
  - Effective divisor is STEP_DIV >> level, and the prescaler compares against that value minus 1.
  - A level change takes effect at the next prescaler wrap.
- `TUBE_SPEEDUP_EN` undefined:
  - The divisor is fixed at STEP_DIV and no level logic is present.

## Test plan
1. **Reset and idle hold:** `clr` 1 cycle, no `start` for 50 cycles → x=320/560/800, y=240/240/150, `running`=0, `pass`=0 throughout.
2. **First move latency:** STEP_DIV=4, `start` at edge E0 → x1=319, x2=559, x3=799 after edge E0+4; unchanged at E0+1..E0+3.
3. **Wrap and gap range:** STEP_DIV=2, run 1000 ticks → every wrap sets x to 719 with the other tubes 240/480 away; every recycled y is in 120..360.
4. **Pass pulse:** STEP_DIV=2, run until x1 reaches 100 → exactly one 1-cycle `pass` pulse, occurring the cycle after the tick that set x1=100 (tick 220).
5. **Freeze and collision:** assert `over` on a tick cycle → no move that edge, state FROZEN; `start` pulses ignored; positions constant for 100 cycles; `clr` restores reset values.
6. **Speedup (`TUBE_SPEEDUP_EN` defined):** STEP_DIV=8, run until 8 passes → tick interval drops from 8 to 4 cycles; it reaches 1 after 24 passes and stays at 1.
